muldiv_unit: RTL and testbench

Parametrised integer multiply/divide execution unit for the RV32 pipeline. It implements the full RISC-V M-extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). Multiplies use a fixed-latency pipeline; divides use an iterative radix-2 unit. The block sits beside the ALU in EX, and its `busy` output feeds the hazard unit's stall logic, so the pipeline holds EX while an operation is in flight.

---
 rtl/muldiv_if.sv | 23 ++
 rtl/muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1, rs2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rs1, rs2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32 M-extension execution unit: fixed-latency multiply, iterative radix-2 restoring divide.
// Optional MULDIV_FAST_SPECIAL_EN: divide-by-zero / signed overflow complete one cycle after start.
module muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic    CPU_CLK,
  input  logic    CPU_RST,
  muldiv_if.slave bus
);
  localparam int MCW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam int DCW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_ITER, DIV_FIX} stateT;

  stateT           stateReg, stateNext;
  logic [2:0]      opReg;
  logic [XLEN-1:0] aReg, bReg, quoReg, remReg;
  logic            quoNegReg, remNegReg, divZeroReg;
  logic [MCW-1:0]  mulCntReg;
  logic [DCW-1:0]  divCntReg;
  logic [XLEN-1:0] resultReg, resultNext;
  logic            doneReg, doneNext;

  logic            accept, opSigned, rs1Neg, rs2Neg, rs2Zero;
  logic [XLEN-1:0] absRs1, absRs2;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] quoFinal, remFinal, divResult;

  // Operands are sign/zero-extended to 2*XLEN so one unsigned multiply covers all four ops.
  function automatic logic [XLEN-1:0] mulCalc(input logic [2:0] o,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic            sgnA, sgnB;
    logic [2*XLEN-1:0] extA, extB, prod;
    sgnA = ((o == 3'd1) || (o == 3'd2)) && a[XLEN-1];
    sgnB = (o == 3'd1) && b[XLEN-1];
    extA = {{XLEN{sgnA}}, a};
    extB = {{XLEN{sgnB}}, b};
    prod = extA * extB;
    return (o == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  assign accept   = (stateReg == IDLE) && bus.start && !bus.flush;
  assign opSigned = ~bus.op[0];
  assign rs1Neg   = opSigned & bus.rs1[XLEN-1];
  assign rs2Neg   = opSigned & bus.rs2[XLEN-1];
  assign rs2Zero  = (bus.rs2 == '0);
  assign absRs1   = rs1Neg ? -bus.rs1 : bus.rs1;
  assign absRs2   = rs2Neg ? -bus.rs2 : bus.rs2;

  assign shifted  = {remReg, quoReg[XLEN-1]};
  assign trial    = shifted - {1'b0, bReg};

`ifdef MULDIV_FAST_SPECIAL_EN
  logic            fastSpecial;
  logic [XLEN-1:0] specialResult;
  assign fastSpecial = bus.op[2] && (rs2Zero ||
                       (opSigned && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1)));
  assign specialResult = rs2Zero ? (bus.op[1] ? bus.rs1 : '1)
                                 : (bus.op[1] ? '0 : bus.rs1);
`endif

  // Sign fix-up; divide-by-zero overrides the datapath, overflow falls out naturally.
  always_comb begin
    quoFinal = quoNegReg ? -quoReg : quoReg;
    remFinal = remNegReg ? -remReg : remReg;
    if (divZeroReg) begin
      quoFinal = '1;
      remFinal = aReg;
    end
    divResult = opReg[1] ? remFinal : quoFinal;
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      stateReg  <= IDLE;
      resultReg <= '0;
      doneReg   <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      resultReg <= resultNext;
      doneReg   <= doneNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    resultNext = resultReg;
    doneNext   = 1'b0;
    unique case (stateReg)
      IDLE: begin
        if (accept) begin
          if (!bus.op[2]) begin
            if (MUL_LATENCY == 1) begin
              resultNext = mulCalc(bus.op, bus.rs1, bus.rs2);
              doneNext   = 1'b1;
            end else begin
              stateNext = MUL_WAIT;
            end
          end else begin
`ifdef MULDIV_FAST_SPECIAL_EN
            if (fastSpecial) begin
              resultNext = specialResult;
              doneNext   = 1'b1;
            end else begin
              stateNext = DIV_ITER;
            end
`else
            stateNext = DIV_ITER;
`endif
          end
        end
      end
      MUL_WAIT: begin
        if (mulCntReg <= MCW'(1)) begin
          resultNext = mulCalc(opReg, aReg, bReg);
          doneNext   = 1'b1;
          stateNext  = IDLE;
        end
      end
      DIV_ITER: begin
        if (divCntReg == DCW'(XLEN-1)) stateNext = DIV_FIX;
      end
      DIV_FIX: begin
        resultNext = divResult;
        doneNext   = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Flush dominates everything, including a completion due this cycle.
    if (bus.flush) begin
      stateNext  = IDLE;
      resultNext = resultReg;
      doneNext   = 1'b0;
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      opReg      <= '0;
      aReg       <= '0;
      bReg       <= '0;
      quoReg     <= '0;
      remReg     <= '0;
      quoNegReg  <= 1'b0;
      remNegReg  <= 1'b0;
      divZeroReg <= 1'b0;
      mulCntReg  <= '0;
      divCntReg  <= '0;
    end else if (accept) begin
      opReg      <= bus.op;
      aReg       <= bus.rs1;
      bReg       <= bus.op[2] ? absRs2 : bus.rs2;
      quoReg     <= absRs1;
      remReg     <= '0;
      quoNegReg  <= rs1Neg ^ rs2Neg;
      remNegReg  <= rs1Neg;
      divZeroReg <= rs2Zero;
      mulCntReg  <= MCW'(MUL_LATENCY - 1);
      divCntReg  <= '0;
    end else begin
      unique case (stateReg)
        MUL_WAIT: begin
          if (mulCntReg != '0) mulCntReg <= mulCntReg - 1'b1;
        end
        DIV_ITER: begin
          // Restoring step: the dividend shifts out of quoReg while quotient bits shift in.
          if (!trial[XLEN]) begin
            remReg <= trial[XLEN-1:0];
            quoReg <= {quoReg[XLEN-2:0], 1'b1};
          end else begin
            remReg <= shifted[XLEN-1:0];
            quoReg <= {quoReg[XLEN-2:0], 1'b0};
          end
          divCntReg <= (divCntReg == DCW'(XLEN-1)) ? '0 : divCntReg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (stateReg != IDLE);
  assign bus.done   = doneReg;
  assign bus.result = resultReg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32, MUL_LATENCY=2): directed M-extension vectors,
// flush, back-to-back, ignored start and asynchronous reset.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int MUL_LAT = 2;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          cyc;
  } expEntryT;

  logic clk;
  logic rstN;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  expEntryT expQ[$];

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .MUL_LATENCY(MUL_LAT)) dut (
    .CPU_CLK (clk),
    .CPU_RST (rstN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no end of test, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Pops the oldest expectation whenever done pulses; also flags late or unexpected completions.
  task automatic monitor();
    expEntryT e;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (bus.done) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done result %h at cycle %0d, required no done",
                     bus.result, cyc);
          end else begin
            e = expQ.pop_front();
            chk({e.name, "_result"}, bus.result, e.res);
            chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
          end
        end else if (expQ.size() > 0 && cyc >= expQ[0].cyc) begin
          e = expQ.pop_front();
          checks++;
          errors++;
          $display("FAIL %s_missing_done: got no done by cycle %0d, required done at cycle %0d",
                   e.name, cyc, e.cyc);
        end
      end
    end
  endtask

  // Issues in the current cycle N and returns in cycle N+lat, the expected done cycle.
  task automatic runOp(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat,
                       input int spurious);
    int n;
    n = cyc;
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs1   = a;
    bus.rs2   = b;
    expQ.push_back('{name, res, n + lat});
    step();
    bus.start = 1'b0;
    while (cyc < n + lat) begin
      if (cyc == n + 1 || cyc == n + lat - 1) chk({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
      if (spurious > 0 && cyc == n + spurious) begin
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.rs1   = 32'd5;
        bus.rs2   = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    chk({name, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n;
    rstN      = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'd0;
    bus.rs1   = '0;
    bus.rs2   = '0;
    fork
      monitor();
    join_none
    step();
    step();
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    rstN = 1'b1;
    step();

    // Every op is issued in the done cycle of the previous one.
    runOp("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 0);
    runOp("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 0);
    runOp("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 0);
    runOp("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT, 0);
    runOp("div",    3'd4, 32'd100,      32'd7,        32'd14,       DIV_LAT, 5);
    runOp("b2b_mul",3'd0, 32'd3,        32'd5,        32'd15,       MUL_LAT, 0);
    runOp("rem_neg",3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, 0);
    runOp("remu",   3'd7, 32'd100,      32'd7,        32'd2,        DIV_LAT, 0);
    runOp("div_neg",3'd4, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, DIV_LAT, 0);
    runOp("divu_big",3'd5,32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, DIV_LAT, 0);
    runOp("divu_z", 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, SPEC_LAT, 0);
    runOp("rem_z",  3'd6, 32'd5,        32'd0,        32'd5,        SPEC_LAT, 0);
    runOp("div_ovf",3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC_LAT, 0);
    runOp("rem_ovf",3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        SPEC_LAT, 0);
    runOp("div_negz",3'd4,32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPEC_LAT, 0);
    runOp("rem_negz",3'd6,32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SPEC_LAT, 0);

    // Flush a divide at N+10: no done, idle at N+11, result held.
    n = cyc;
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.rs1   = 32'd100;
    bus.rs2   = 32'd7;
    step();
    bus.start = 1'b0;
    while (cyc < n + 10) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_result_hold", bus.result, 32'hFFFFFFFB);
    runOp("post_flush_mul", 3'd0, 32'd6, 32'd7, 32'd42, MUL_LAT, 0);

    // Start together with flush is dropped.
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 3'd0;
    bus.rs1   = 32'd9;
    bus.rs2   = 32'd9;
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_beats_start_busy", {31'd0, bus.busy}, 32'd0);
    step();
    step();
    chk("flush_beats_start_result", bus.result, 32'd42);

    // Asynchronous reset in the middle of a divide.
    n = cyc;
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.rs1   = 32'd100;
    bus.rs2   = 32'd7;
    step();
    bus.start = 1'b0;
    while (cyc < n + 5) step();
    rstN = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset_done", {31'd0, bus.done}, 32'd0);
    chk("midreset_result", bus.result, 32'd0);
    step();
    step();
    rstN = 1'b1;
    step();
    runOp("divu_after_reset", 3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT, 0);

    step();
    step();
    step();
    chk("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
